ex_muldiv_unit: RTL and testbench

//   EX-stage multiply/divide unit. It consumes the A/B operands produced by the EX operand-select

---
 rtl/ex_muldiv_unit_pkg.sv | 23 ++
 rtl/ex_div_core.sv | 48 ++++
 rtl/ex_muldiv_unit.sv | 157 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared mul/div operation codes and FSM state encodings.
// Imported by ID decode and the EX multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [2:0] {
        MD_OP_MULT  = 3'd0,
        MD_OP_MULTU = 3'd1,
        MD_OP_DIV   = 3'd2,
        MD_OP_DIVU  = 3'd3,
        MD_OP_MTHI  = 3'd4,
        MD_OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2,
        MD_ST_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/ex_div_core.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Iterates every cycle after load; the caller samples after DATA_W steps.
module ex_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              ge;

    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
        ge      = ~diff[DATA_W];
        rem_d   = ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
        quo_d   = {quo_q[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
// MUL takes one extra cycle, DIV takes DATA_W iterations plus a sign fix-up.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e         state_q, state_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              msgn_q, msgn_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic              div_load;
    logic              dsgn;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W-1:0] quo, rem;
    logic [2*DATA_W-1:0] ma, mb, prod;

    assign dsgn  = (op == MD_OP_DIV);
    assign abs_a = (dsgn && A[DATA_W-1]) ? -A : A;
    assign abs_b = (dsgn && B[DATA_W-1]) ? -B : B;

    assign ma   = {{DATA_W{msgn_q & a_q[DATA_W-1]}}, a_q};
    assign mb   = {{DATA_W{msgn_q & b_q[DATA_W-1]}}, b_q};
    assign prod = ma * mb;

    ex_div_core #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        msgn_d   = msgn_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div_load = 1'b0;
        if (flush) begin
            state_d = MD_ST_IDLE;
        end else begin
            unique case (state_q)
                MD_ST_IDLE: begin
                    if (start) begin
                        unique case (op)
                            MD_OP_MTHI: hi_d = A;
                            MD_OP_MTLO: lo_d = A;
                            MD_OP_MULT, MD_OP_MULTU: begin
                                a_d     = A;
                                b_d     = B;
                                msgn_d  = (op == MD_OP_MULT);
                                state_d = MD_ST_MUL;
                            end
                            MD_OP_DIV, MD_OP_DIVU: begin
                                a_d      = A;
                                b_d      = B;
                                qneg_d   = dsgn & (A[DATA_W-1] ^ B[DATA_W-1]);
                                rneg_d   = dsgn & A[DATA_W-1];
                                cnt_d    = '0;
                                div_load = 1'b1;
                                state_d  = MD_ST_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                MD_ST_MUL: begin
                    {hi_d, lo_d} = prod;
                    done_d       = 1'b1;
                    state_d      = MD_ST_IDLE;
                end
                MD_ST_DIV: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = MD_ST_FIX;
                    end
                end
                MD_ST_FIX: begin
                    // Divide by zero reports all-ones quotient and the raw dividend
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = qneg_q ? -quo : quo;
                        hi_d = rneg_q ? -rem : rem;
                    end
                    done_d  = 1'b1;
                    state_d = MD_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            msgn_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            msgn_q  <= msgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign busy = (state_q != MD_ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors, monitor checks each done pulse.
// Stimulus pushes expected HI/LO and arrival cycle; the monitor pops on done.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t q[$];
    int   cyc;
    int   t0;
    int   n_pass;
    int   n_total;
    int   n_done;

    ex_muldiv_unit #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (resetn && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        t0    = cyc;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.cyc = t0 + lat;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        if (i == 100) chk({name, "_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
        chk({name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({name, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int nd;
        n_pass  = 0;
        n_total = 0;
        n_done  = 0;
        resetn  = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 3'd0;
        A       = '0;
        B       = '0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        resetn = 1'b1;

        issue(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        chk("mul_busy", {31'd0, busy}, 32'd1);
        wait_idle("mult");
        issue(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, 2);
        wait_idle("multu");
        issue(MD_OP_MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, 2);
        wait_idle("mult_min");

        issue(MD_OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 34);
        chk("div_busy", {31'd0, busy}, 32'd1);
        wait_idle("divu");
        issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        wait_idle("div_neg");
        issue(MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD, 34);
        wait_idle("div_negb");
        issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000, 34);
        wait_idle("div_ovf");
        issue(MD_OP_DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 34);
        wait_idle("divu_z");
        issue(MD_OP_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34);
        wait_idle("div_z");

        issue(MD_OP_MTHI, 32'h1234, 32'd0, 0, 0, 0, 0);
        issue(MD_OP_MTLO, 32'h5678, 32'd0, 0, 0, 0, 0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);
        chk("mt_busy", {31'd0, busy}, 32'd0);

        nd = n_done;
        issue(MD_OP_DIV, 32'd1000, 32'd3, 0, 0, 0, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h5678);
        repeat (40) @(negedge clk);
        chk("flush_nodone", 32'(n_done - nd), 32'd0);

        nd = n_done;
        issue(MD_OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 34);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = MD_OP_MULTU;
        A     = 32'd3;
        B     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_idle("busy_start");
        repeat (5) @(negedge clk);
        chk("busy_start_one_done", 32'(n_done - nd), 32'd1);
        chk("busy_start_hi", hi, 32'd2);

        issue(MD_OP_MTHI, 32'hDEAD_BEEF, 32'd0, 0, 0, 0, 0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = MD_OP_MTHI;
        A     = 32'h1111_1111;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("mthi_flush_hi", hi, 32'hDEAD_BEEF);

        nd = n_done;
        issue(MD_OP_MULT, 32'd6, 32'd7, 0, 0, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("mulflush_hi", hi, 32'hDEAD_BEEF);
        chk("mulflush_lo", lo, 32'd14);
        chk("mulflush_nodone", 32'(n_done - nd), 32'd0);

        nd = n_done;
        issue(MD_OP_MULT, 32'd7, 32'd9, 0, 0, 0, 0);
        #1 resetn = 1'b0;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        #1 resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_nodone", 32'(n_done - nd), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
